alu_bist: RTL
=============

# alu_bist

Built-in self-test engine for the MIPS ALU, driving the ALU's opcode/a/b inputs and consuming its result. On a start request it sweeps every opcode over a pseudo-random sequence of operand pairs and compresses each result into a 32-bit MISR signature. At the end it compares the signature against a golden value and reports pass/fail. It sits beside the datapath ALU and is muxed onto the ALU inputs during test.

## Interface
- NUM_OPS, 9: opcodes exercised, 0 .. NUM_OPS-1, range 1..16
- NUM_VECTORS, 16: operand pairs generated, ≥1
- SEED, 32'h0000_0001: LFSR seed, must be non-zero
- GOLDEN_SIG, 32'h0000_0000: expected final signature
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  run request, sampled in IDLE/DONE
- opcode  output  4  ALU opcode, registered
- a  output  32  ALU operand a, registered
- b  output  32  ALU operand b, registered
- result  input  32  ALU result, combinational function of opcode/a/b
- busy  output  1  run in progress
- done  output  1  run finished, held until next start
- pass  output  1  signature == GOLDEN_SIG; valid while done=1
- signature  output  32  current MISR value

## Operation
- States: IDLE, ISSUE, CAPTURE, COMPARE, DONE.
- IDLE/DONE + start=1: load opcode=0, lfsr=SEED, a=lfsr, b={lfsr[15:0],lfsr[31:16]}^32'h5A5A5A5A, sig=0, done=0, pass=0, busy=1 → ISSUE.
- ISSUE: one settle cycle → CAPTURE.
- CAPTURE: sig ← {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ result. Then:
  - opcode<NUM_OPS-1: opcode+1 → ISSUE.
  - opcode wraps, vectors remain: opcode=0; LFSR steps once (Galois, taps 32'h8020_0003, shift right, XOR taps when lsb=1); a, b reload → ISSUE.
  - last op of last vector → COMPARE.
- COMPARE: pass ← (sig==GOLDEN_SIG), done ← 1, busy ← 0 → DONE.
- start while busy: ignored. start in DONE: restart as from IDLE.
- opcode/a/b hold their last values in DONE; return to 0 only on reset or abort.

## Timing
- Reset (async, immediate): state IDLE; opcode=0, a=0, b=0, busy=0, done=0, pass=0, signature=0, internal counters 0.
- Total ops N = NUM_OPS*NUM_VECTORS. Each op takes 2 cycles (ISSUE+CAPTURE).
- start sampled at edge k → busy=1 after k. Capture of op i at edge k+2+2i. done=1, busy=0 after edge k+2N+1.
- rst mid-run: outputs to reset values without waiting for a clock edge; the run is lost.

## Configuration
- ALU_BIST_ABORT_EN defined: adds input port abort (1 bit). abort=1 in ISSUE/CAPTURE/COMPARE → IDLE at next edge; busy=0, done=0, pass=0, opcode/a/b=0; signature holds. abort is ignored in IDLE/DONE. abort has priority over start.
- ALU_BIST_ABORT_EN undefined: no abort port; a run always completes.

## Structure
- Package alu_bist_pkg: state encoding, LFSR tap constant 32'h8020_0003, MISR feedback tap positions, operand-b XOR mask 32'h5A5A5A5A, opcode width 4.
- Sub-module alu_bist_misr: 32-bit signature register with clear and enable inputs. The LFSR and FSM stay in the top level.

## Test plan
- Reset: assert rst between edges → all outputs 0 immediately; after release with start=0 for 10 cycles, outputs stay 0.
- NUM_OPS=9, NUM_VECTORS=1, stub result=0, GOLDEN_SIG=0: one-cycle start pulse → opcode steps 0..8, each held 2 cycles; a=32'h0000_0001, b=32'h5A5B_5A5A; done after 19 edges; pass=1; signature=0.
- NUM_OPS=1, NUM_VECTORS=1, stub result=32'h1: signature=32'h0000_0001. With GOLDEN_SIG=1 → pass=1; with GOLDEN_SIG=0 → pass=0.
- start held high for a whole run: run length unchanged at 2N+1. start high in DONE: done clears at the next edge and a new run begins.
- Async rst asserted at cycle 7 of a run: outputs zero before the next edge; after release the engine sits in IDLE until a new start.
- ALU_BIST_ABORT_EN defined, abort pulse at cycle 5: IDLE after the next edge; busy=0, done=0, opcode=0, a=0, b=0.

Source files
------------

// File: rtl/alu_bist_pkg.sv
// Shared constants, state encoding and LFSR/operand helpers for the ALU BIST engine.
package alu_bist_pkg;

    localparam int OPC_W = 4;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] B_MASK    = 32'h5A5A_5A5A;

    // MISR feedback bit positions, XORed into the shifted-in bit
    localparam int MISR_TAP0 = 31;
    localparam int MISR_TAP1 = 21;
    localparam int MISR_TAP2 = 1;
    localparam int MISR_TAP3 = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_COMPARE,
        ST_DONE
    } state_t;

    // Galois form: shift right, fold taps in when the bit shifted out is 1
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
    endfunction

    function automatic logic [31:0] operand_b(input logic [31:0] l);
        return {l[15:0], l[31:16]} ^ B_MASK;
    endfunction

endpackage

// File: rtl/alu_bist_misr.sv
// 32-bit multiple-input signature register compressing one ALU result per enable.
module alu_bist_misr
    import alu_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] din,
    output logic [31:0] sig
);

    logic fb;

    assign fb = sig[MISR_TAP0] ^ sig[MISR_TAP1] ^ sig[MISR_TAP2] ^ sig[MISR_TAP3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sig <= '0;
        else if (clr)
            sig <= '0;
        else if (en)
            sig <= {sig[30:0], fb} ^ din;
    end

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test: sweeps all opcodes over LFSR operand pairs into a MISR.
// Optional abort input enabled by defining ALU_BIST_ABORT_EN.
module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int          NUM_OPS     = 9,
    parameter int          NUM_VECTORS = 16,
    parameter logic [31:0] SEED        = 32'h0000_0001,
    parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
`ifdef ALU_BIST_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    output logic [OPC_W-1:0] opcode,
    output logic [31:0]      a,
    output logic [31:0]      b,
    input  logic [31:0]      result,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [31:0]      signature
);

    localparam int               VEC_W    = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam logic [OPC_W-1:0] LAST_OP  = OPC_W'(NUM_OPS - 1);
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

    state_t           state, state_nxt;
    logic [31:0]      lfsr, lfsr_nxt;
    logic [VEC_W-1:0] vec_cnt;
    logic             kill, last_op, last_vec;
    logic             do_load, do_capture, do_next_op, do_next_vec, do_compare;

`ifdef ALU_BIST_ABORT_EN
    assign kill = abort && (state == ST_ISSUE || state == ST_CAPTURE || state == ST_COMPARE);
`else
    assign kill = 1'b0;
`endif

    assign last_op  = (opcode == LAST_OP);
    assign last_vec = (vec_cnt == LAST_VEC);
    assign lfsr_nxt = lfsr_step(lfsr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (kill)
            state_nxt = ST_IDLE;
        else begin
            case (state)
                ST_IDLE, ST_DONE: if (start) state_nxt = ST_ISSUE;
                ST_ISSUE:         state_nxt = ST_CAPTURE;
                ST_CAPTURE:       state_nxt = (last_op && last_vec) ? ST_COMPARE : ST_ISSUE;
                ST_COMPARE:       state_nxt = ST_DONE;
                default:          state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        do_load     = start && (state == ST_IDLE || state == ST_DONE);
        do_capture  = !kill && (state == ST_CAPTURE);
        do_next_op  = do_capture && !last_op;
        do_next_vec = do_capture && last_op && !last_vec;
        do_compare  = !kill && (state == ST_COMPARE);
    end

    // Operand, counter and status registers; abort clears everything except the signature
    always_ff @(posedge clk or posedge rst) begin
        if (rst || kill) begin
            opcode  <= '0;
            a       <= '0;
            b       <= '0;
            lfsr    <= '0;
            vec_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else if (do_load) begin
            opcode  <= '0;
            lfsr    <= SEED;
            a       <= SEED;
            b       <= operand_b(SEED);
            vec_cnt <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else if (do_next_op) begin
            opcode <= opcode + 1'b1;
        end else if (do_next_vec) begin
            opcode  <= '0;
            lfsr    <= lfsr_nxt;
            a       <= lfsr_nxt;
            b       <= operand_b(lfsr_nxt);
            vec_cnt <= vec_cnt + 1'b1;
        end else if (do_compare) begin
            pass <= (signature == GOLDEN_SIG);
            done <= 1'b1;
            busy <= 1'b0;
        end
    end

    alu_bist_misr u_misr (
        .clk (clk),
        .rst (rst),
        .clr (do_load),
        .en  (do_capture),
        .din (result),
        .sig (signature)
    );

endmodule
